add_sub_accumulator: RTL and testbench

Sequencing stage directly upstream of the 4-bit add/sub core. It accepts an opcode/operand stream over a valid/ready handshake, drives the core with the accumulator as operand A, and registers the result and flags. It presents the new accumulator value downstream with its own valid/ready handshake and keeps a sticky overflow flag for the control path.

---
 rtl/add_sub_accumulator_pkg.sv | 15 +
 rtl/universal_add_sub.sv | 23 ++
 rtl/add_sub_accumulator.sv | 106 ++++++++++
 tb/tb_add_sub_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_accumulator_pkg.sv
// Shared opcode and FSM state definitions for the add/sub accumulator.
package add_sub_accumulator_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/universal_add_sub.sv
// Combinational two's-complement add/subtract core with carry and signed overflow.
module universal_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtract as a + ~b + 1, so carry_out=1 means no borrow.
    assign b_eff     = b ^ {WIDTH{mode}};
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};
    assign result    = sum[WIDTH-1:0];
    assign carry_out = sum[WIDTH];
    assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/add_sub_accumulator.sv
// Accumulator sequencer: accepts op/operand commands, drives the add/sub core,
// and holds each result with its flags until downstream accepts it.
//
//   state  | meaning
//   S_IDLE | ready for a command (in_ready=1)
//   S_EXEC | one cycle: core evaluates acc op latched data, registers update
//   S_HOLD | result presented (out_valid=1) until out_ready
module add_sub_accumulator
    import add_sub_accumulator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             sticky_ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             accept;

    universal_add_sub #(.WIDTH(WIDTH)) u_core (
        .a         (acc),
        .b         (data_q),
        .mode      (op_q == OP_SUB),
        .result    (core_result),
        .carry_out (core_carry),
        .overflow  (core_ovf)
    );

    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_HOLD);
    assign out_acc   = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_LOAD;
            data_q     <= '0;
            acc        <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            sticky_ovf <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= in_op;
                data_q <= in_data;
            end
            if (state == S_EXEC) begin
                case (op_q)
                    OP_LOAD: begin
                        acc       <= data_q;
                        out_carry <= 1'b0;
                        out_ovf   <= 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        acc        <= core_result;
                        out_carry  <= core_carry;
                        out_ovf    <= core_ovf;
                        sticky_ovf <= sticky_ovf | core_ovf;
                    end
                    default: begin
                        acc        <= '0;
                        out_carry  <= 1'b0;
                        out_ovf    <= 1'b0;
                        sticky_ovf <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed bench for add_sub_accumulator with hand-computed expected results.
module tb_add_sub_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'b00;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_acc;
    logic       out_carry;
    logic       out_ovf;
    logic       sticky_ovf;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    add_sub_accumulator #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_res(input string tag, input logic [3:0] acc_e, input logic c_e,
                           input logic o_e, input logic s_e);
        chk({tag, ".acc"}, 32'(out_acc), 32'(acc_e));
        chk({tag, ".carry"}, 32'(out_carry), 32'(c_e));
        chk({tag, ".ovf"}, 32'(out_ovf), 32'(o_e));
        chk({tag, ".sticky"}, 32'(sticky_ovf), 32'(s_e));
    endtask

    // Present a command, wait for acceptance, and stop once the result is in HOLD.
    task automatic send(input string tag, input logic [1:0] op, input logic [3:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
        in_op    = op;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".exec_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk_res("rst", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // 1: 5 + 3 overflows into -8
        send("t1.load5", 2'b00, 4'd5);
        chk_res("t1.load5", 4'd5, 1'b0, 1'b0, 1'b0);
        drain("t1.load5");
        send("t1.add3", 2'b01, 4'd3);
        chk_res("t1.add3", 4'b1000, 1'b0, 1'b1, 1'b1);
        drain("t1.add3");

        // 2: subtraction with and without borrow
        send("t2.load3", 2'b00, 4'd3);
        drain("t2.load3");
        send("t2.sub5", 2'b10, 4'd5);
        chk_res("t2.sub5", 4'b1110, 1'b0, 1'b0, 1'b1);
        drain("t2.sub5");
        send("t2.load7", 2'b00, 4'd7);
        drain("t2.load7");
        send("t2.sub2", 2'b10, 4'd2);
        chk_res("t2.sub2", 4'b0101, 1'b1, 1'b0, 1'b1);
        drain("t2.sub2");

        // 3: negative overflow, unsigned wrap, clear
        send("t3.load8", 2'b00, 4'd8);
        drain("t3.load8");
        send("t3.sub1", 2'b10, 4'd1);
        chk_res("t3.sub1", 4'b0111, 1'b1, 1'b1, 1'b1);
        drain("t3.sub1");
        send("t3.load15", 2'b00, 4'd15);
        drain("t3.load15");
        send("t3.add1", 2'b01, 4'd1);
        chk_res("t3.add1", 4'd0, 1'b1, 1'b0, 1'b1);
        drain("t3.add1");
        send("t3.clr", 2'b11, 4'd6);
        chk_res("t3.clr", 4'd0, 1'b0, 1'b0, 1'b0);
        drain("t3.clr");

        // 4: backpressure with a command waiting upstream
        send("t4.load6", 2'b00, 4'd6);
        in_op    = 2'b01;
        in_data  = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4.hold.valid", 32'(out_valid), 32'd1);
            chk("t4.hold.in_ready", 32'(in_ready), 32'd0);
            chk_res("t4.hold", 4'd6, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t4.release.valid", 32'(out_valid), 32'd0);
        chk("t4.release.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4.accept.in_ready", 32'(in_ready), 32'd0);
        chk("t4.accept.valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t4.result.valid", 32'(out_valid), 32'd1);
        chk_res("t4.add1", 4'd7, 1'b0, 1'b0, 1'b0);
        drain("t4.add1");

        // 5a: reset during EXEC
        @(negedge clk);
        in_op    = 2'b00;
        in_data  = 4'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5a.valid", 32'(out_valid), 32'd0);
        chk("t5a.acc", 32'(out_acc), 32'd0);
        chk("t5a.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5a.post.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("t5a.post.valid", 32'(out_valid), 32'd0);
        chk("t5a.post.acc", 32'(out_acc), 32'd0);

        // 5b: reset during HOLD
        send("t5b.load3", 2'b00, 4'd3);
        chk_res("t5b.load3", 4'd3, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5b.valid", 32'(out_valid), 32'd0);
        chk("t5b.acc", 32'(out_acc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5b.post.in_ready", 32'(in_ready), 32'd1);
        send("t5b.load9", 2'b00, 4'd9);
        chk_res("t5b.load9", 4'd9, 1'b0, 1'b0, 1'b0);
        drain("t5b.load9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
